// File: rtl/sensor_conditioner.sv
// Sensor front end for the alarm controller: it synchronizes and debounces the
// arm, motion and door inputs, and emits one-cycle rise pulses. A window FSM
// turns a door rise that follows a motion rise into a single confirm pulse.
module sensor_conditioner #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned WINDOW    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm_raw,
    input  logic       motion_raw,
    input  logic       door_raw,
    input  logic       clear,
    output logic       arm_o,
    output logic       trig_o,
    output logic       conf_o,
    output logic       window_open,
    output logic [7:0] window_cnt,
    output logic [2:0] db_level
);

    localparam logic [7:0] DbLast  = 8'(DB_CYCLES - 1);
    localparam logic [7:0] WinLoad = 8'(WINDOW);

    typedef enum logic [1:0] {StIdle, StOpen, StHoldoff} state_e;

    // Channel order everywhere: bit 0 arm, bit 1 motion, bit 2 door
    logic [2:0] raw;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] lvl_q;
    logic [7:0] cnt_q [3];
    logic [2:0] accept, rise;
    logic       arm_q, trig_q, conf_q;
    logic [7:0] win_q;
    state_e     state_q;

    assign raw = {door_raw, motion_raw, arm_raw};

    // Two-flop synchronizer on every raw input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Decode which channels flip their debounced level at this edge
    always_comb begin
        accept = '0;
        rise   = '0;
        for (int i = 0; i < 3; i++) begin
            accept[i] = (sync2_q[i] != lvl_q[i]) && (cnt_q[i] == DbLast);
            rise[i]   = accept[i] & sync2_q[i];
        end
    end

    // Debounce counters: count while synced value disagrees, restart on agreement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (accept[i]) begin
                    lvl_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Arm and trigger pulses follow accepted rises regardless of window state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_q  <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            arm_q  <= rise[0];
            trig_q <= rise[1];
        end
    end

    // Confirm-window FSM; clear overrides every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            win_q   <= '0;
            conf_q  <= 1'b0;
        end else begin
            conf_q <= 1'b0;
            if (clear) begin
                state_q <= StIdle;
                win_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // A door rise alongside the motion rise cannot confirm
                        if (rise[1]) begin
                            state_q <= StOpen;
                            win_q   <= WinLoad;
                        end
                    end
                    StOpen: begin
                        // Door rise checked first so it wins over expiry
                        if (rise[2]) begin
                            conf_q  <= 1'b1;
                            win_q   <= '0;
                            state_q <= StHoldoff;
                        end else if (win_q == 8'd1) begin
                            win_q   <= '0;
                            state_q <= StIdle;
                        end else begin
                            win_q <= win_q - 8'd1;
                        end
                    end
                    StHoldoff: begin
                        if (lvl_q[2:1] == 2'b00) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        win_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign arm_o       = arm_q;
    assign trig_o      = trig_q;
    assign conf_o      = conf_q;
    assign window_open = (state_q == StOpen);
    assign window_cnt  = win_q;
    assign db_level    = lvl_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed steps with hand-computed pulse cycles
// queued as expectations; a negedge monitor pops one entry per observed pulse.
module tb_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm_raw = 1'b0;
    logic       motion_raw = 1'b0;
    logic       door_raw = 1'b0;
    logic       clear = 1'b0;
    logic       arm_o, trig_o, conf_o, window_open;
    logic [7:0] window_cnt;
    logic [2:0] db_level;

    sensor_conditioner #(
        .DB_CYCLES (4),
        .WINDOW    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .arm_raw     (arm_raw),
        .motion_raw  (motion_raw),
        .door_raw    (door_raw),
        .clear       (clear),
        .arm_o       (arm_o),
        .trig_o      (trig_o),
        .conf_o      (conf_o),
        .window_open (window_open),
        .window_cnt  (window_cnt),
        .db_level    (db_level)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected pulse: cycle count at which it is visible, and {conf, trig, arm}
    typedef struct {
        int         cyc;
        logic [2:0] p;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   n_vec = 0;
    int   n_err = 0;

    // Monitor: every pulse the DUT shows must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && ({conf_o, trig_o, arm_o} != 3'b000)) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL pulse_unexpected cyc=%0d got=%b want=none", cyc,
                         {conf_o, trig_o, arm_o});
            end else begin
                e_mon = q.pop_front();
                if (e_mon.cyc != cyc || e_mon.p != {conf_o, trig_o, arm_o}) begin
                    n_err++;
                    $display("FAIL pulse cyc=%0d got=%b want=%b at cyc %0d", cyc,
                             {conf_o, trig_o, arm_o}, e_mon.p, e_mon.cyc);
                end
            end
        end
    end

    task automatic run_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_pulse(input int c, input logic [2:0] p);
        exp_t e;
        e.cyc = c;
        e.p   = p;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // Anything left in the queue is a pulse that never appeared
    task automatic drain(input string name);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing_pulse got=%0d pending want=0 (first at cyc %0d)",
                     name, q.size(), q[0].cyc);
            q.delete();
        end
    endtask

    int c;
    int r;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_db_level", int'(db_level), 0);
        chk("rst_window_open", int'(window_open), 0);
        chk("rst_window_cnt", int'(window_cnt), 0);
        chk("rst_pulses", int'({conf_o, trig_o, arm_o}), 0);
        rst_n = 1'b1;
        run_to(cyc + 2);

        // Arm step: pulse 6 cycles after the step, level follows the same cycle
        c = cyc;
        arm_raw = 1'b1;
        expect_pulse(c + 6, 3'b001);
        run_to(c + 5);
        chk("arm_level_before", int'(db_level), 0);
        run_to(c + 6);
        chk("arm_level_after", int'(db_level), 1);
        run_to(c + 10);
        drain("arm");

        // Three-cycle motion glitch must be rejected
        c = cyc;
        motion_raw = 1'b1;
        run_to(c + 3);
        motion_raw = 1'b0;
        run_to(c + 12);
        chk("glitch_level", int'(db_level), 1);
        chk("glitch_cnt", int'(dut.cnt_q[1]), 0);
        chk("glitch_window", int'(window_open), 0);
        drain("glitch");

        // Motion then door 10 cycles later: confirm, then holdoff
        c = cyc;
        motion_raw = 1'b1;
        expect_pulse(c + 6, 3'b010);
        expect_pulse(c + 16, 3'b100);
        run_to(c + 6);
        chk("conf_open", int'(window_open), 1);
        chk("conf_cnt_load", int'(window_cnt), 16);
        run_to(c + 10);
        door_raw = 1'b1;
        run_to(c + 15);
        chk("conf_cnt_mid", int'(window_cnt), 7);
        run_to(c + 16);
        chk("conf_closed", int'(window_open), 0);
        chk("conf_cnt_zero", int'(window_cnt), 0);
        // Holdoff: motion re-rise while door still high must not reopen
        run_to(c + 20);
        motion_raw = 1'b0;
        run_to(c + 30);
        motion_raw = 1'b1;
        expect_pulse(c + 36, 3'b010);
        run_to(c + 37);
        chk("holdoff_no_reopen", int'(window_open), 0);
        run_to(c + 40);
        motion_raw = 1'b0;
        door_raw = 1'b0;
        run_to(c + 50);
        drain("confirm");

        // Expiry with no door, then a late door rise in IDLE is ignored
        c = cyc;
        motion_raw = 1'b1;
        expect_pulse(c + 6, 3'b010);
        run_to(c + 6);
        chk("exp_cnt16", int'(window_cnt), 16);
        run_to(c + 13);
        chk("exp_cnt9", int'(window_cnt), 9);
        run_to(c + 21);
        chk("exp_cnt1", int'(window_cnt), 1);
        chk("exp_open_last", int'(window_open), 1);
        run_to(c + 22);
        chk("exp_cnt0", int'(window_cnt), 0);
        chk("exp_closed", int'(window_open), 0);
        door_raw = 1'b1;
        run_to(c + 30);
        motion_raw = 1'b0;
        door_raw = 1'b0;
        run_to(c + 40);
        drain("expiry");

        // Door rise in the final window cycle still confirms
        c = cyc;
        motion_raw = 1'b1;
        expect_pulse(c + 6, 3'b010);
        expect_pulse(c + 22, 3'b100);
        run_to(c + 16);
        door_raw = 1'b1;
        run_to(c + 21);
        chk("last_cnt1", int'(window_cnt), 1);
        run_to(c + 22);
        chk("last_closed", int'(window_open), 0);
        chk("last_db", int'(db_level), 7);
        run_to(c + 25);
        motion_raw = 1'b0;
        door_raw = 1'b0;
        run_to(c + 40);
        drain("last_cycle");

        // Clear at window_cnt 5 with a door rise the same cycle
        c = cyc;
        motion_raw = 1'b1;
        expect_pulse(c + 6, 3'b010);
        run_to(c + 12);
        door_raw = 1'b1;
        run_to(c + 17);
        chk("clr_cnt5", int'(window_cnt), 5);
        clear = 1'b1;
        run_to(c + 18);
        clear = 1'b0;
        chk("clr_cnt0", int'(window_cnt), 0);
        chk("clr_closed", int'(window_open), 0);
        run_to(c + 20);
        motion_raw = 1'b0;
        door_raw = 1'b0;
        run_to(c + 32);
        drain("clear");

        // Repeated motion rise inside the window does not reload the count
        c = cyc;
        motion_raw = 1'b1;
        expect_pulse(c + 6, 3'b010);
        run_to(c + 7);
        motion_raw = 1'b0;
        run_to(c + 14);
        motion_raw = 1'b1;
        expect_pulse(c + 20, 3'b010);
        run_to(c + 20);
        chk("reload_cnt", int'(window_cnt), 2);
        chk("reload_open", int'(window_open), 1);
        run_to(c + 22);
        chk("reload_expired", int'(window_cnt), 0);
        run_to(c + 23);
        motion_raw = 1'b0;
        run_to(c + 35);
        drain("reload");

        // Simultaneous motion and door rise from IDLE: open, no confirm
        c = cyc;
        motion_raw = 1'b1;
        door_raw = 1'b1;
        expect_pulse(c + 6, 3'b010);
        run_to(c + 6);
        chk("simul_open", int'(window_open), 1);
        chk("simul_cnt", int'(window_cnt), 16);
        run_to(c + 8);
        motion_raw = 1'b0;
        door_raw = 1'b0;
        run_to(c + 30);
        drain("simul");

        // Reset mid-window with every input high, then re-debounce
        c = cyc;
        motion_raw = 1'b1;
        door_raw = 1'b1;
        expect_pulse(c + 6, 3'b010);
        run_to(c + 10);
        chk("pre_rst_open", int'(window_open), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_db", int'(db_level), 0);
        chk("rst_mid_open", int'(window_open), 0);
        chk("rst_mid_cnt", int'(window_cnt), 0);
        chk("rst_mid_pulses", int'({conf_o, trig_o, arm_o}), 0);
        run_to(c + 13);
        rst_n = 1'b1;
        r = cyc;
        expect_pulse(r + 6, 3'b011);
        run_to(r + 6);
        chk("rerise_open", int'(window_open), 1);
        chk("rerise_cnt", int'(window_cnt), 16);
        run_to(r + 8);
        arm_raw = 1'b0;
        motion_raw = 1'b0;
        door_raw = 1'b0;
        run_to(r + 24);
        chk("rerise_expired", int'(window_open), 0);
        drain("reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
SENSOR_CONDITIONER -- requirements
Module: sensor_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 4, debounce acceptance length in cycles (range 1..255).
REQ-002 Parameter WINDOW, default 16, confirm window length in cycles (range 1..255).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 arm_raw  input  1  raw arm keyswitch, asynchronous to clk.
REQ-006 motion_raw  input  1  raw motion sensor, asynchronous to clk.
REQ-007 door_raw  input  1  raw door contact, asynchronous to clk.
REQ-008 clear  input  1  synchronous abort of confirm window.
REQ-009 arm_o  output  1  one-cycle pulse on accepted arm rise; feeds alarm FSM arm input.
REQ-010 trig_o  output  1  one-cycle pulse on accepted motion rise; feeds FSM trigger input.
REQ-011 conf_o  output  1  one-cycle pulse on door rise inside window; feeds FSM confirm input.
REQ-012 window_open  output  1  high while window FSM in OPEN.
REQ-013 window_cnt  output  8  remaining window cycles; 0 outside OPEN.
REQ-014 db_level  output  3  debounced levels {door, motion, arm}.

Function
REQ-015 Each raw input SHALL pass a 2-flop synchronizer before any other use.
REQ-016 Per channel, an 8-bit counter SHALL increment each cycle synced value differs from debounced level, and reset to 0 when equal.
REQ-017 Debounced level SHALL take the synced value at the edge where the counter equals DB_CYCLES-1 and the values still differ; the counter returns to 0 at that edge.
REQ-018 A single-sample glitch shorter than DB_CYCLES SHALL not change any debounced level.
REQ-019 Rise pulses SHALL be registered: high exactly the one cycle after the edge at which debounced level goes 0->1; falls produce no pulse.
REQ-020 Raw-to-pulse latency for a clean step SHALL be 2 + DB_CYCLES cycles.
REQ-021 arm_o and trig_o SHALL pulse on every accepted rise of their channel, independent of window state.
REQ-022 Window FSM states: IDLE, OPEN, HOLDOFF.
REQ-023 IDLE: motion rise -> OPEN, window_cnt loaded with WINDOW; door rise ignored, no conf_o.
REQ-024 OPEN: window_cnt decrements by 1 per cycle; door rise -> conf_o pulse, window_cnt <= 0, -> HOLDOFF.
REQ-025 OPEN: at window_cnt==1 with no door rise -> IDLE, window_cnt <= 0 (expiry).
REQ-026 OPEN: door rise in the expiry cycle (window_cnt==1) SHALL confirm; confirm beats expiry.
REQ-027 OPEN: repeated motion rise SHALL NOT reload window_cnt (trig_o still pulses).
REQ-028 IDLE: simultaneous motion and door rise -> OPEN and trig_o, no conf_o.
REQ-029 HOLDOFF: remain until debounced motion and door both 0, then -> IDLE; no conf_o in HOLDOFF.
REQ-030 clear high: FSM -> IDLE, window_cnt <= 0, conf_o suppressed that cycle; debounce and arm_o/trig_o unaffected; clear has priority over every transition.
REQ-031 At most one conf_o pulse per window.

Reset
REQ-032 rst_n low SHALL asynchronously clear synchronizers, counters, debounced levels, pulses, window_cnt to 0 and FSM to IDLE.
REQ-033 Reset mid-window SHALL abort the window with no conf_o; after release, inputs already high SHALL be re-debounced and produce a fresh rise pulse.
REQ-034 rst_n deassertion is synchronized externally; block needs no internal release logic.

Verification
REQ-035 DB_CYCLES=4: arm_raw 0->1 held -> arm_o single pulse exactly 6 cycles after step, db_level[0]=1.
REQ-036 motion_raw 3-cycle glitch -> no trig_o, db_level[1] stays 0, counter back to 0.
REQ-037 WINDOW=16: motion rise then door rise 10 cycles later -> trig_o, window_open, conf_o once, FSM HOLDOFF until both low.
REQ-038 Motion rise, no door -> window_cnt 16..1 then 0, window_open drops after 16 cycles, no conf_o; door rise in final cycle -> conf_o.
REQ-039 clear asserted with window_cnt=5 and door rising same cycle -> no conf_o, window_cnt=0, IDLE.
REQ-040 rst_n low during OPEN with all inputs held high -> outputs 0; after release, arm_o and trig_o pulse again 6 cycles later, FSM enters OPEN.
